uart_tx: RTL and testbench

8-N-1 UART transmitter: the send-side counterpart of the 8-N-1 receiver. It accepts a byte over a valid/ready handshake and serialises it LSB-first as start bit, 8 data bits and stop bit on `tx_o`. Bit timing comes from a fractional-N phase accumulator (NCO), so non-integer clk/baud ratios carry no cumulative drift. It sits between the host-link command logic and the board's TX pin.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_baud_nco.sv | 40 ++++
 rtl/uart_tx.sv | 150 +++++++++++++++
 tb/tb_uart_tx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types, constants and NCO increment helper.
// UART_TX_PARITY_EN adds the PARITY state for 8-E-1 framing.
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } uart_tx_state_e;

    // round(baud * mult * 2^acc_width / clk_hz) in 64-bit arithmetic
    function automatic logic [63:0] nco_incr(
        input logic [63:0] clk_hz,
        input logic [63:0] baud,
        input logic [63:0] mult,
        input int          acc_width
    );
        logic [63:0] num;
        num = (baud * mult) << acc_width;
        return (num + (clk_hz >> 1)) / clk_hz;
    endfunction

endpackage

// File: rtl/uart_baud_nco.sv
// Fractional-N phase accumulator; carry out is the bit tick.
// Shared between the UART transmitter and receiver.
module uart_baud_nco #(
    parameter int                   ACC_WIDTH = 24,
    parameter logic [ACC_WIDTH-1:0] INCR      = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick_o
);

    logic [ACC_WIDTH-1:0] phase_q;
    logic [ACC_WIDTH-1:0] phase_d;
    logic [ACC_WIDTH:0]   sum;

    assign sum    = {1'b0, phase_q} + {1'b0, INCR};
    assign tick_o = en & ~clr & sum[ACC_WIDTH];

    // Next phase: clear aligns a new frame, carry is dropped
    always_comb begin
        phase_d = phase_q;
        if (clr) begin
            phase_d = '0;
        end else if (en) begin
            phase_d = sum[ACC_WIDTH-1:0];
        end
    end

    // Phase register
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8-N-1 UART transmitter with NCO bit timing.
// Define UART_TX_PARITY_EN for 8-E-1 frames.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned BAUD      = 115_200,
    parameter int          ACC_WIDTH = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam logic [63:0] INCR64 =
        nco_incr(64'(CLK_HZ), 64'(BAUD), 64'd1, ACC_WIDTH);
    localparam logic [ACC_WIDTH-1:0] INCR = INCR64[ACC_WIDTH-1:0];
    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    if (INCR64 == 64'd0 || INCR64 >= (64'd1 << ACC_WIDTH)) begin : g_incr_bad
        $error("uart_tx: NCO increment out of range");
    end

    uart_tx_state_e state_q;
    uart_tx_state_e state_d;
    logic [7:0]     shift_q;
    logic [7:0]     shift_d;
    logic [2:0]     cnt_q;
    logic [2:0]     cnt_d;
    logic           tx_q;
    logic           tx_d;
    logic           done_q;
    logic           done_d;
    logic           nco_clr;
    logic           bit_tick;
    logic           idle;
`ifdef UART_TX_PARITY_EN
    logic           par_q;
    logic           par_d;
`endif

    assign idle    = (state_q == ST_IDLE);
    assign ready_o = idle;
    assign busy_o  = ~idle;
    assign tx_o    = tx_q;
    assign done_o  = done_q;

    uart_baud_nco #(
        .ACC_WIDTH (ACC_WIDTH),
        .INCR      (INCR)
    ) u_nco (
        .clk    (clk),
        .rst    (rst),
        .clr    (nco_clr),
        .en     (busy_o),
        .tick_o (bit_tick)
    );

    // Frame sequencing and line level derived from the next state
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        nco_clr = 1'b0;
        tx_d    = UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    state_d = ST_START;
                    shift_d = data_i;
                    cnt_d   = '0;
                    nco_clr = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^data_i;
`endif
                end
            end
            ST_START: begin
                if (bit_tick) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_tick) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (bit_tick) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_q;
`endif
            default:   tx_d = UART_IDLE_LEVEL;
        endcase
    end

    // State, datapath and registered line outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            tx_q    <= UART_IDLE_LEVEL;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues bytes,
// a line monitor checks every clock of each frame.
module tb_uart_tx;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int AW     = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NSEG = 11;
`else
    localparam int NSEG = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_i = 8'h00;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic       tx_o;
    logic       busy_o;
    logic       done_o;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    int         bnd[0:NSEG];

    always #5 clk = ~clk;

    uart_tx #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .ACC_WIDTH (AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .tx_o    (tx_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    task automatic check(input string name, input logic [7:0] got,
                         input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h expected %02h", name, got, exp);
        end
    endtask

    // Line level t clocks after acceptance, from bit-boundary table
    function automatic logic exp_line(input logic [7:0] b, input int t);
        int s;
        s = 0;
        for (int n = 1; n <= NSEG; n++) begin
            if (t >= bnd[n]) s = n;
        end
        if (s == 0) return 1'b0;
        if (s <= 8) return b[s-1];
        if (NSEG == 11 && s == 9) return ^b;
        return 1'b1;
    endfunction

    // Monitor: outputs sampled on the falling edge
    initial begin : monitor
        logic       active;
        logic       rst_prev;
        int         t;
        logic [7:0] cur;
        longint     incr;
        active   = 1'b0;
        rst_prev = 1'b1;
        t        = 0;
        cur      = 8'h00;
        incr = (longint'(BAUD) * 65536 + CLK_HZ / 2) / CLK_HZ;
        for (int n = 0; n <= NSEG; n++) begin
            bnd[n] = int'((longint'(n) * 65536 + incr - 1) / incr);
        end
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (rst_prev) begin
                check("reset {tx,busy,ready,done}",
                      {4'b0, tx_o, busy_o, ready_o, done_o}, 8'h0A);
                active = 1'b0;
            end else if (active) begin
                t++;
                if (t == bnd[NSEG]) begin
                    check($sformatf("frame %02h end", cur),
                          {4'b0, tx_o, busy_o, ready_o, done_o}, 8'h0B);
                    active = 1'b0;
                end else begin
                    check($sformatf("frame %02h t=%0d", cur, t),
                          {4'b0, tx_o, busy_o, ready_o, done_o},
                          {4'b0, exp_line(cur, t), 3'b100});
                end
            end else begin
                check("idle {tx,busy,ready,done}",
                      {4'b0, tx_o, busy_o, ready_o, done_o}, 8'h0A);
            end
            if (!active && !rst && valid_i && ready_o) begin
                check("accept has queued byte",
                      {7'b0, exp_q.size() > 0}, 8'h01);
                if (exp_q.size() > 0) begin
                    cur    = exp_q.pop_front();
                    active = 1'b1;
                    t      = -1;
                end
            end
            rst_prev = rst;
        end
    end

    task automatic wait_accept();
        logic got;
        got = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            got = ready_o & valid_i;
        end
        check("accept timeout", {7'b0, got}, 8'h01);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        logic got;
        got = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            got = ~busy_o;
        end
        check("idle timeout", {7'b0, got}, 8'h01);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic noisy);
        exp_q.push_back(b);
        data_i  = b;
        valid_i = 1'b1;
        wait_accept();
        valid_i = 1'b0;
        if (noisy) begin
            repeat (5) @(posedge clk);
            for (int k = 0; k < 60; k++) begin
                #1;
                data_i  = (k % 3 == 0) ? 8'hFF : 8'($urandom);
                valid_i = 1'($urandom);
                @(posedge clk);
            end
            #1;
            valid_i = 1'b0;
        end
        wait_idle();
    endtask

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
        exp_q.push_back(a);
        exp_q.push_back(b);
        data_i  = a;
        valid_i = 1'b1;
        wait_accept();
        data_i = b;
        wait_accept();
        valid_i = 1'b0;
        wait_idle();
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        send(8'h55, 1'b0);
        send_pair(8'hA3, 8'h00);
        send(8'h3C, 1'b1);

        exp_q.push_back(8'h96);
        data_i  = 8'h96;
        valid_i = 1'b1;
        wait_accept();
        valid_i = 1'b0;
        repeat (44) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send(8'hC4, 1'b0);
        send(8'h07, 1'b0);
        send(8'h03, 1'b0);

        for (int i = 0; i < 20; i++) begin
            int mode;
            mode = $urandom_range(0, 2);
            if (mode == 2) send_pair(8'($urandom), 8'($urandom));
            else send(8'($urandom), mode == 1);
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
        end

        repeat (5) @(posedge clk);
        check("queue drained", 8'(exp_q.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
